// File: rtl/netlist_bist_pkg.sv
// Shared types and step functions for the netlist BIST controller.
// The LFSR and MISR step functions are pure so that a reference model can
// reuse them bit-for-bit.
package netlist_bist_pkg;

  localparam int BIST_W = 16;

  // Feedback taps at bits 15,13,12,10 : x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [BIST_W-1:0] TAP_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  // One Fibonacci LFSR shift: feedback bit enters at bit 0
  function automatic logic [BIST_W-1:0] lfsr_step(input logic [BIST_W-1:0] p);
    return {p[BIST_W-2:0], ^(p & TAP_MASK)};
  endfunction

  // One MISR compaction: LFSR shift of the signature xor the response word
  function automatic logic [BIST_W-1:0] misr_step(input logic [BIST_W-1:0] s,
                                                 input logic [BIST_W-1:0] r);
    return lfsr_step(s) ^ r;
  endfunction

endpackage

// File: rtl/netlist_bist_ctrl_misr16.sv
// 16-bit multiple-input signature register. clr has priority over en.
module misr16 import netlist_bist_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BIST_W-1:0] d,
  output logic [BIST_W-1:0] sig
);

  logic [BIST_W-1:0] sig_q, sig_d;

  // Next signature: clear on run start, compact when enabled, else hold
  always_comb begin
    sig_d = sig_q;
    if (clr)     sig_d = '0;
    else if (en) sig_d = misr_step(sig_q, d);
  end

  // Signature register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/netlist_bist_ctrl.sv
// BIST driver/compactor for 16-in/16-out combinational netlists.
// LFSR drives pat_out, MISR compacts resp_in, signature compared to
// GOLDEN_SIG at the end of the run.
// Optional macro NETLIST_BIST_RESP_REG_EN registers the netlist response
// before compaction and adds a one-cycle FLUSH state; the signature is
// unchanged, busy is one cycle longer.
module netlist_bist_ctrl import netlist_bist_pkg::*; #(
  parameter int                N_PATTERNS = 256,
  parameter logic [BIST_W-1:0] SEED       = 16'hACE1,
  parameter logic [BIST_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIST_W-1:0] resp_in,
  output logic [BIST_W-1:0] pat_out,
  output logic              busy,
  output logic              done,
  output logic [BIST_W-1:0] signature,
  output logic              pass
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1
  localparam logic [BIST_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;
  localparam logic [BIST_W-1:0] LAST_CNT = BIST_W'(N_PATTERNS - 1);

  bist_state_e       state_q, state_d;
  logic [BIST_W-1:0] cnt_q, cnt_d;
  logic [BIST_W-1:0] pat_q, pat_d;
  logic              pass_q, pass_d;
  logic              misr_clr, misr_en;
  logic [BIST_W-1:0] misr_d;
  logic [BIST_W-1:0] sig;
  logic [BIST_W-1:0] sig_next;

`ifdef NETLIST_BIST_RESP_REG_EN
  logic [BIST_W-1:0] resp_q, resp_d;
  logic              resp_vld_q, resp_vld_d;
  assign misr_d = resp_q;
`else
  assign misr_d = resp_in;
`endif

  // Signature as it will be after this edge's compaction; feeds pass
  assign sig_next = misr_step(sig, misr_d);

  // Next-state, counter, LFSR and compaction control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
`ifdef NETLIST_BIST_RESP_REG_EN
    resp_d     = resp_q;
    resp_vld_d = resp_vld_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pat_d    = SEED_EFF;
          cnt_d    = '0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
          state_d  = RUN;
`ifdef NETLIST_BIST_RESP_REG_EN
          resp_vld_d = 1'b0;
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
`ifdef NETLIST_BIST_RESP_REG_EN
        // Compact the previous cycle's response, capture this one
        misr_en    = resp_vld_q;
        resp_d     = resp_in;
        resp_vld_d = 1'b1;
        if (cnt_q == LAST_CNT) state_d = FLUSH;
        else                   pat_d   = lfsr_step(pat_q);
`else
        misr_en = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          pass_d  = (sig_next == GOLDEN_SIG);
        end else begin
          pat_d = lfsr_step(pat_q);
        end
`endif
      end
`ifdef NETLIST_BIST_RESP_REG_EN
      FLUSH: begin
        // Last captured response still pending in resp_q
        misr_en    = 1'b1;
        resp_vld_d = 1'b0;
        pass_d     = (sig_next == GOLDEN_SIG);
        state_d    = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      pass_q  <= pass_d;
    end
  end

`ifdef NETLIST_BIST_RESP_REG_EN
  // Response pipeline register breaking the LFSR->netlist->MISR path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q     <= '0;
      resp_vld_q <= 1'b0;
    end else begin
      resp_q     <= resp_d;
      resp_vld_q <= resp_vld_d;
    end
  end
`endif

  misr16 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .d   (misr_d),
    .sig (sig)
  );

  assign pat_out   = pat_q;
  assign busy      = (state_q == RUN) || (state_q == FLUSH);
  assign done      = (state_q == DONE);
  assign signature = sig;
  assign pass      = pass_q;

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Bench for netlist_bist_ctrl: small fixed-parameter instances checked from a
// vector table, plus a closed-loop instance driving a randomised netlist and
// checked against an arithmetic reference model.
module tb_netlist_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

`ifdef NETLIST_BIST_RESP_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  int n_tot = 0;
  int n_pass = 0;

  logic [15:0] a_pat, a_sig, b_pat, b_sig, c_pat, c_sig, z_pat, z_sig, m_pat, m_sig;
  logic a_busy, a_done, a_pass, b_busy, b_done, b_pass, c_busy, c_done, c_pass;
  logic z_busy, z_done, z_pass, m_busy, m_done, m_pass;
  logic [15:0] m_resp;
  logic [15:0] nk1 = 16'h0001;
  logic [15:0] nk2 = 16'h0000;
  logic [15:0] exp_pat [256];

  // ---- reference model ----
  function automatic logic [15:0] m_lfsr(input logic [15:0] p);
    return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
  endfunction
  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [15:0] r);
    return m_lfsr(s) ^ r;
  endfunction
  // Stand-in combinational netlist, shape picked by random keys
  function automatic logic [15:0] net_f(input logic [15:0] p, input logic [15:0] k1,
                                        input logic [15:0] k2);
    return ((p * k1) + k2) ^ {p[7:0], p[15:8]};
  endfunction

  always_comb m_resp = net_f(m_pat, nk1, nk2);

  // a: pattern sequence; b/c: compaction with two goldens; z: zero seed; m: closed loop
  netlist_bist_ctrl #(.N_PATTERNS(3), .SEED(16'h0001), .GOLDEN_SIG(16'h0000)) u_a (
    .clk(clk), .rst(rst), .start(start), .resp_in(16'h0000), .pat_out(a_pat),
    .busy(a_busy), .done(a_done), .signature(a_sig), .pass(a_pass));
  netlist_bist_ctrl #(.N_PATTERNS(2), .SEED(16'h0001), .GOLDEN_SIG(16'h0003)) u_b (
    .clk(clk), .rst(rst), .start(start), .resp_in(16'h0001), .pat_out(b_pat),
    .busy(b_busy), .done(b_done), .signature(b_sig), .pass(b_pass));
  netlist_bist_ctrl #(.N_PATTERNS(2), .SEED(16'h0001), .GOLDEN_SIG(16'h0004)) u_c (
    .clk(clk), .rst(rst), .start(start), .resp_in(16'h0001), .pat_out(c_pat),
    .busy(c_busy), .done(c_done), .signature(c_sig), .pass(c_pass));
  netlist_bist_ctrl #(.N_PATTERNS(4), .SEED(16'h0000), .GOLDEN_SIG(16'h0000)) u_z (
    .clk(clk), .rst(rst), .start(start), .resp_in(16'h0000), .pat_out(z_pat),
    .busy(z_busy), .done(z_done), .signature(z_sig), .pass(z_pass));
  netlist_bist_ctrl u_m (
    .clk(clk), .rst(rst), .start(start), .resp_in(m_resp), .pat_out(m_pat),
    .busy(m_busy), .done(m_done), .signature(m_sig), .pass(m_pass));

  logic any_out;
  assign any_out = |{a_pat, a_sig, b_pat, b_sig, c_pat, c_sig, z_pat, z_sig, m_pat, m_sig,
                     a_busy, a_done, a_pass, b_busy, b_done, b_pass, c_busy, c_done, c_pass,
                     z_busy, z_done, z_pass, m_busy, m_done, m_pass};

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %04h expected %04h", nm, act, exp);
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // ---- vector table: start drive, then expected values after that edge ----
  typedef struct packed {
    logic        st;
    logic [15:0] a_pat;
    logic        a_busy, a_done, a_pass;
    logic [15:0] b_sig;
    logic        b_busy, b_done, b_pass;
    logic        c_pass;
    logic [15:0] z_pat;
  } vec_t;
  vec_t tbl[$];

  task automatic fill_table();
`ifdef NETLIST_BIST_RESP_REG_EN
    tbl.push_back('{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001});
    tbl.push_back('{1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002});
    tbl.push_back('{1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004});
    tbl.push_back('{1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0008});
    tbl.push_back('{1'b0, 16'h0004, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0008});
    tbl.push_back('{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0008});
    tbl.push_back('{1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0008});
`else
    tbl.push_back('{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001});
    tbl.push_back('{1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002});
    tbl.push_back('{1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0004});
    tbl.push_back('{1'b0, 16'h0004, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0008});
    tbl.push_back('{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0008});
    tbl.push_back('{1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0008});
`endif
  endtask

  // Expected pattern list for the default-parameter instance
  task automatic build_pats();
    logic [15:0] p;
    p = 16'hACE1;
    for (int i = 0; i < 256; i++) begin
      exp_pat[i] = p;
      p = m_lfsr(p);
    end
  endtask

  // One full closed-loop run on u_m, with a start pulse injected mid-run
  task automatic run_closed(input string nm);
    logic [15:0] s;
    int cyc, errs;
    s = 16'h0000;
    for (int i = 0; i < 256; i++) s = m_misr(s, net_f(exp_pat[i], nk1, nk2));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    errs = 0;
    while (m_busy && cyc < 600) begin
      if (m_pat !== exp_pat[(cyc < 256) ? cyc : 255]) errs++;
      cyc++;
      start = (cyc == 10);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk16({nm, "_busy_cycles"}, 16'(cyc), 16'(256 + LAT));
    chk16({nm, "_pat_seq_errs"}, 16'(errs), 16'h0000);
    chk1({nm, "_done"}, m_done, 1'b1);
    chk16({nm, "_signature"}, m_sig, s);
    chk1({nm, "_pass"}, m_pass, (s == 16'h0000));
    chk16({nm, "_pat_hold"}, m_pat, exp_pat[255]);
  endtask

  initial begin
    fill_table();
    build_pats();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_outputs_zero", any_out, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("idle_no_busy", m_busy | m_done, 1'b0);

    foreach (tbl[i]) begin
      start = tbl[i].st;
      @(posedge clk); #1;
      chk16($sformatf("r%0d_a_pat", i), a_pat, tbl[i].a_pat);
      chk1($sformatf("r%0d_a_busy", i), a_busy, tbl[i].a_busy);
      chk1($sformatf("r%0d_a_done", i), a_done, tbl[i].a_done);
      chk1($sformatf("r%0d_a_pass", i), a_pass, tbl[i].a_pass);
      chk16($sformatf("r%0d_a_sig", i), a_sig, 16'h0000);
      chk16($sformatf("r%0d_b_sig", i), b_sig, tbl[i].b_sig);
      chk1($sformatf("r%0d_b_busy", i), b_busy, tbl[i].b_busy);
      chk1($sformatf("r%0d_b_done", i), b_done, tbl[i].b_done);
      chk1($sformatf("r%0d_b_pass", i), b_pass, tbl[i].b_pass);
      chk1($sformatf("r%0d_c_pass", i), c_pass, tbl[i].c_pass);
      chk16($sformatf("r%0d_z_pat", i), z_pat, tbl[i].z_pat);
    end
    start = 1'b0;

    // Clear everything, then reset in the middle of a run
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    nk1 = 16'($urandom) | 16'h0001;
    nk2 = 16'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk16("pre_reset_pat5", m_pat, exp_pat[5]);
    chk1("pre_reset_busy", m_busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("midrun_reset_async_zero", any_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("after_reset_idle", m_busy | m_done, 1'b0);
    chk16("after_reset_sig", m_sig, 16'h0000);

    run_closed("run1");
    nk1 = 16'($urandom) | 16'h0001;
    nk2 = 16'($urandom);
    run_closed("run2");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/netlist_bist_ctrl.md
# netlist_bist_ctrl

Built-in self-test driver and response compactor for the 16-input / 16-output combinational fault-simulation netlists. It is the other end of the netlist's port boundary: it drives pseudo-random vectors into `in0..in15` from a 16-bit LFSR and compacts `out0..out15` into a 16-bit MISR signature. At the end of a run it compares the signature against a golden value. Fault-simulation runs use it to obtain good-machine and faulty-machine signatures cycle-accurately.

## Interface
- `N_PATTERNS`, default 256: patterns applied per run; legal range 1..65535.
- `SEED`, default 16'hACE1: first LFSR pattern. A value of 0 is replaced by 16'h0001.
- `GOLDEN_SIG`, default 16'h0000: expected fault-free signature.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a run.
- `resp_in`  in  16  netlist outputs; bit k = `out`k.
- `pat_out`  out  16  pattern to netlist; bit k drives `in`k.
- `busy`  out  1  run in progress.
- `done`  out  1  level; run finished, `signature` and `pass` valid.
- `signature`  out  16  MISR contents.
- `pass`  out  1  `signature == GOLDEN_SIG`; meaningful only while `done`=1.

## Operation
- States: IDLE, RUN, FLUSH (macro builds only), DONE.
- LFSR step: `lfsr_next = {p[14:0], p[15]^p[13]^p[12]^p[10]}` (x^16+x^14+x^13+x^11+1).
- MISR step: `s_next = {s[14:0], s[15]^s[13]^s[12]^s[10]} ^ r`.
- IDLE or DONE, `start`=1 at the edge:
  - `pat_out`←SEED (or 16'h0001 if SEED is 0)
  - `signature`←0, `cnt`←0, `done`←0, `pass`←0
  - go to RUN.
- RUN, at each edge:
  - `signature`←MISR step of `resp_in`
  - `pat_out`←lfsr_next, `cnt`←`cnt`+1.
  - When `cnt == N_PATTERNS-1`, go to DONE and leave `pat_out` unchanged instead of stepping it.
- DONE:
  - `pass` is registered on DONE entry.
  - `pat_out`, `signature`, `pass` hold until the next `start`.
- `start` while `busy`=1 is ignored (no restart, no error).
- `cnt` is 16-bit. N_PATTERNS=1 gives a single RUN cycle.

## Timing
- Reset values: `pat_out`=0, `signature`=0, `busy`=0, `done`=0, `pass`=0, state IDLE, `cnt`=0.
- Netlist path is combinational. `resp_in` is sampled at the same edge that advances `pat_out`, so each pattern is held exactly one cycle.
- Without the macro:
  - `busy` is high for exactly N_PATTERNS cycles, starting the cycle after the `start` edge.
  - `done` rises the cycle after the last compaction.
- Reset asserted mid-run aborts immediately to the reset values. No partial signature is retained.
- `start` held high across consecutive DONE→RUN transitions starts back-to-back runs with no IDLE cycle.

## Configuration
- `NETLIST_BIST_RESP_REG_EN` defined:
  - adds a `resp_q` register and `resp_vld` flag between `resp_in` and the MISR. This breaks the LFSR→netlist→MISR path for long netlists.
  - The MISR compacts `resp_q` only when `resp_vld`=1.
  - After the last pattern, a one-cycle FLUSH state compacts the final response.
  - `busy` lasts N_PATTERNS+1 cycles.
  - The signature is identical to the non-macro build for the same netlist.
- Not defined: no `resp_q`, no FLUSH state, timing exactly as above.

## Structure
- `netlist_bist_pkg` holds:
  - `BIST_W` = 16
  - the tap mask 16'hB400 (bits 15,13,12,10)
  - the state enum
  - pure functions `lfsr_step` and `misr_step`, shared with the simulator's reference model.
- One sub-module, `misr16` (clk, rst, clr, en, d, sig), is natural. The FSM, counter and LFSR stay in the top.

## Test plan
- Reset mid-run:
  - Stimulus: assert `rst` during RUN at pattern 5.
  - Required: all outputs return to 0 asynchronously (before the next edge), state IDLE. A new `start` runs normally.
- Pattern sequence:
  - Stimulus: SEED=16'h0001, N_PATTERNS=3, `resp_in`=0.
  - Required: `pat_out` = 0001, 0002, 0004 on successive RUN cycles; `busy` high 3 cycles; `signature`=0000.
  - With GOLDEN_SIG=0, `pass`=1.
- Compaction:
  - Stimulus: N_PATTERNS=2, `resp_in` held 16'h0001.
  - Required: `signature`=0001 after the first edge and 0003 at DONE.
  - With GOLDEN_SIG=0003, `pass`=1; with GOLDEN_SIG=0004, `pass`=0.
- SEED=0: first `pat_out` is 0001.
- Ignored start: `start` pulsed mid-RUN has no effect on `cnt` or `signature`.
- Macro build, closed loop:
  - Stimulus: `NETLIST_BIST_RESP_REG_EN` defined, N_PATTERNS=256, netlist connected, SEED=16'hACE1.
  - Required: `busy` high 257 cycles; signature equals the non-macro build and the package-function model.
